// File: rtl/scanchain_ctrl_mc_if.sv
// DMA-side bundle of the scan controller: command channel, read stream, write stream.
// master: the scan controller (issues commands, sinks rd beats, sources wr beats).
// slave : the DMA engine (accepts commands, sources rd beats, sinks wr beats).
interface scanchain_ctrl_mc_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_dir;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_count;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output cmd_valid, cmd_dir, cmd_addr, cmd_count, rd_ready, wr_valid, wr_data,
    input  cmd_ready, rd_valid, rd_data, wr_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_addr, cmd_count, rd_ready, wr_valid, wr_data,
    output cmd_ready, rd_valid, rd_data, wr_ready
  );
endinterface

// File: rtl/scanchain_ctrl_mc.sv
// Multi-chain checkpoint scan controller: moves CHAIN_COUNT scan chains to/from one DMA engine.
// Ports: host_clk/host_rst; start/direction/base_addr/chain_mask/abort control in; busy/done/aborted
// status out; dma (command + rd/wr streams, master side); sc_se/sc_sr/sc_sd/sc_di/sc_do chain side.
module scanchain_ctrl_mc #(
  parameter int CHAIN_COUNT = 2,
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 16,
  parameter logic [CHAIN_COUNT*LEN_WIDTH-1:0] CHAIN_LENS = {16'd4, 16'd3},
  parameter logic [CHAIN_COUNT*4-1:0]         CHAIN_PREP = {4'd2, 4'd0}
) (
  input  logic                              host_clk,
  input  logic                              host_rst,
  input  logic                              start,
  input  logic                              direction,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [CHAIN_COUNT-1:0]            chain_mask,
  input  logic                              abort,
  output logic                              busy,
  output logic                              done,
  output logic                              aborted,
  output logic [CHAIN_COUNT-1:0]            sc_se,
  output logic [CHAIN_COUNT-1:0]            sc_sr,
  output logic                              sc_sd,
  output logic [DATA_WIDTH-1:0]             sc_di,
  input  logic [CHAIN_COUNT*DATA_WIDTH-1:0] sc_do,
  scanchain_ctrl_mc_if.master               dma
);

  localparam int IDXW = (CHAIN_COUNT > 1) ? $clog2(CHAIN_COUNT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_SEL, ST_RST, ST_PREP, ST_SCAN, ST_DONE
  } state_t;

  state_t                 state;
  logic                   dir_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_WIDTH-1:0]   total_q;
  logic [CHAIN_COUNT-1:0] rem_q;
  logic [IDXW-1:0]        cur_q;
  logic [LEN_WIDTH-1:0]   cnt_q;
  logic [3:0]             pcnt_q;
  logic                   done_q;
  logic                   aborted_q;
  logic                   cmd_valid_q;
  logic [CHAIN_COUNT-1:0] sc_sr_q;

  // Chains with a zero length are dropped from the mask; total wraps at LEN_WIDTH.
  logic [CHAIN_COUNT-1:0] eff_mask;
  logic [LEN_WIDTH-1:0]   total;
  always_comb begin
    eff_mask = '0;
    total    = '0;
    for (int i = 0; i < CHAIN_COUNT; i++) begin
      if (chain_mask[i] && (CHAIN_LENS[i*LEN_WIDTH +: LEN_WIDTH] != '0)) begin
        eff_mask[i] = 1'b1;
        total       = total + CHAIN_LENS[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // Lowest remaining chain; scanning downwards lets the lowest index win.
  logic [IDXW-1:0]        sel_idx;
  logic [CHAIN_COUNT-1:0] sel_onehot;
  logic                   sel_any;
  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
    for (int i = CHAIN_COUNT - 1; i >= 0; i--) begin
      if (rem_q[i]) begin
        sel_idx    = IDXW'(i);
        sel_onehot = '0;
        sel_onehot[i] = 1'b1;
      end
    end
    sel_any = |rem_q;
  end

  // Per-chain attributes of the chain currently being serviced.
  logic [LEN_WIDTH-1:0]   cur_len;
  logic [3:0]             cur_prep;
  logic [DATA_WIDTH-1:0]  cur_do;
  logic [CHAIN_COUNT-1:0] cur_onehot;
  always_comb begin
    cur_len    = '0;
    cur_prep   = '0;
    cur_do     = '0;
    cur_onehot = '0;
    for (int i = 0; i < CHAIN_COUNT; i++) begin
      if (cur_q == IDXW'(i)) begin
        cur_len       = CHAIN_LENS[i*LEN_WIDTH +: LEN_WIDTH];
        cur_prep      = CHAIN_PREP[i*4 +: 4];
        cur_do        = sc_do[i*DATA_WIDTH +: DATA_WIDTH];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  logic in_scan;
  logic beat;
  logic last_beat;
  assign in_scan   = (state == ST_SCAN);
  // Our side of the active stream is always ready/valid in SCAN, so the peer alone decides a beat.
  assign beat      = in_scan && (dir_q ? dma.rd_valid : dma.wr_ready);
  assign last_beat = (cnt_q == (cur_len - LEN_WIDTH'(1)));

  always_ff @(posedge host_clk or posedge host_rst) begin
    if (host_rst) begin
      state       <= ST_IDLE;
      dir_q       <= 1'b0;
      addr_q      <= '0;
      total_q     <= '0;
      rem_q       <= '0;
      cur_q       <= '0;
      cnt_q       <= '0;
      pcnt_q      <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      sc_sr_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      sc_sr_q   <= '0;
      if ((state != ST_IDLE) && abort) begin
        // A beat in this cycle is still taken by the stream, but the chain stops here.
        state       <= ST_IDLE;
        aborted_q   <= 1'b1;
        cmd_valid_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              dir_q   <= direction;
              addr_q  <= base_addr;
              total_q <= total;
              rem_q   <= eff_mask;
              if (|eff_mask) begin
                state       <= ST_CMD;
                cmd_valid_q <= 1'b1;
              end else begin
                state  <= ST_DONE;
                done_q <= 1'b1;
              end
            end
          end
          ST_CMD: begin
            if (dma.cmd_ready) begin
              cmd_valid_q <= 1'b0;
              state       <= ST_SEL;
            end
          end
          ST_SEL: begin
            if (sel_any) begin
              cur_q   <= sel_idx;
              sc_sr_q <= sel_onehot;
              state   <= ST_RST;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
          ST_RST: begin
            cnt_q <= '0;
            // Prep only primes the read pipe of RAM chains; scan-in has nothing to prime.
            if (!dir_q && (cur_prep != 4'd0)) begin
              pcnt_q <= cur_prep;
              state  <= ST_PREP;
            end else begin
              state <= ST_SCAN;
            end
          end
          ST_PREP: begin
            pcnt_q <= pcnt_q - 4'd1;
            if (pcnt_q == 4'd1) state <= ST_SCAN;
          end
          ST_SCAN: begin
            if (beat) begin
              if (last_beat) begin
                rem_q[cur_q] <= 1'b0;
                state        <= ST_SEL;
              end else begin
                cnt_q <= cnt_q + LEN_WIDTH'(1);
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy    = (state != ST_IDLE);
  assign done    = done_q;
  assign aborted = aborted_q;
  assign sc_sr   = sc_sr_q;
  assign sc_sd   = dir_q;

  assign dma.cmd_valid = cmd_valid_q;
  assign dma.cmd_dir   = dir_q;
  assign dma.cmd_addr  = addr_q;
  assign dma.cmd_count = total_q;
  assign dma.rd_ready  = in_scan && dir_q;
  assign dma.wr_valid  = in_scan && !dir_q;
  assign dma.wr_data   = (in_scan && !dir_q) ? cur_do : '0;
  assign sc_di         = (in_scan && dir_q) ? dma.rd_data : '0;

  // The chain only shifts on a taken beat (never during a stall or an aborting cycle).
  assign sc_se = (state == ST_PREP)           ? cur_onehot :
                 (beat && !abort)             ? cur_onehot : '0;

endmodule

// File: tb/tb_scanchain_ctrl_mc.sv
// Directed bench for scanchain_ctrl_mc with a behavioural two-chain scan model.
// Chain i holds words 0x100*(i+1)+k; chain 1 needs two prep shifts before its data appears.
// Streams: wr_ready/rd_valid driven per cycle from a small per-run configuration.
module tb_scanchain_ctrl_mc;
  localparam int CC = 2;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int LW = 16;

  logic host_clk = 1'b0;
  logic host_rst;
  always #5 host_clk = ~host_clk;

  logic          start, direction, abort;
  logic [AW-1:0] base_addr;
  logic [CC-1:0] chain_mask;
  logic          busy, done, aborted, sc_sd;
  logic [CC-1:0] sc_se, sc_sr;
  logic [DW-1:0] sc_di;
  logic [CC*DW-1:0] sc_do;

  scanchain_ctrl_mc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dma ();

  scanchain_ctrl_mc #(
    .CHAIN_COUNT(CC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
    .CHAIN_LENS({16'd4, 16'd3}), .CHAIN_PREP({4'd2, 4'd0})
  ) dut (
    .host_clk(host_clk), .host_rst(host_rst), .start(start), .direction(direction),
    .base_addr(base_addr), .chain_mask(chain_mask), .abort(abort), .busy(busy),
    .done(done), .aborted(aborted), .sc_se(sc_se), .sc_sr(sc_sr), .sc_sd(sc_sd),
    .sc_di(sc_di), .sc_do(sc_do), .dma(dma)
  );

  // Scan chain model: shift count resets on sc_sr and advances on sc_se.
  int se_cnt [CC];
  int prep_of [CC] = '{0, 2};
  always @(posedge host_clk or posedge host_rst) begin
    for (int i = 0; i < CC; i++) begin
      if (host_rst || sc_sr[i]) se_cnt[i] <= 0;
      else if (sc_se[i])        se_cnt[i] <= se_cnt[i] + 1;
    end
  end
  always_comb begin
    sc_do = '0;
    for (int i = 0; i < CC; i++) begin
      if (se_cnt[i] < prep_of[i]) sc_do[i*DW +: DW] = 64'hDEAD;
      else sc_do[i*DW +: DW] = 64'((i + 1) * 256 + se_cnt[i] - prep_of[i]);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Per-run configuration and logs.
  int stall_beat, abort_beat, restart_cyc;
  bit rd_toggle, abort_at_start, rst_in_prep;
  logic [DW-1:0] wr_log[$];
  logic [DW-1:0] di_log[$];
  logic [CC-1:0] sr_log[$];
  int prep_cyc, se0_cnt, se1_cnt, rd_beats, done_cnt, abort_cnt, cmdv_cnt, stall_bad;
  int done_cyc, abort_cyc, abort_apply_cyc, busy_at_abort, cmd_unstable, stall_left;
  logic [AW-1:0] cmd_addr_s;
  logic [LW-1:0] cmd_count_s;
  logic          cmd_dir_s;
  logic [DW-1:0] stall_data;
  logic [DW-1:0] exp_wr [7] = '{64'h100, 64'h101, 64'h102, 64'h200, 64'h201, 64'h202, 64'h203};

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, 64'({busy, done, aborted, sc_se, sc_sr, sc_sd, dma.cmd_valid,
                             dma.cmd_dir, dma.rd_ready, dma.wr_valid}), 64'h0);
    check({tag, "_cmd"}, 64'({dma.cmd_addr, dma.cmd_count}), 64'h0);
    check({tag, "_dat"}, sc_di | dma.wr_data, 64'h0);
  endtask

  task automatic check_wr(input string tag, input int n);
    check({tag, "_nbeats"}, 64'(wr_log.size()), 64'(n));
    for (int k = 0; k < n && k < wr_log.size(); k++)
      check($sformatf("%s_beat%0d", tag, k), wr_log[k], exp_wr[k]);
  endtask

  task automatic run_xfer(input logic dir, input logic [CC-1:0] mask, input logic [AW-1:0] addr);
    int  end_at;
    int  wr_cnt;
    int  rd_cnt;
    bit  finished;
    wr_log.delete(); di_log.delete(); sr_log.delete();
    prep_cyc = 0; se0_cnt = 0; se1_cnt = 0; rd_beats = 0; done_cnt = 0; abort_cnt = 0;
    cmdv_cnt = 0; stall_bad = 0; done_cyc = -1; abort_cyc = -1; abort_apply_cyc = -1;
    busy_at_abort = -1; cmd_unstable = 0; stall_left = 10;
    end_at = -1; wr_cnt = 0; rd_cnt = 0; finished = 0;
    direction = dir; chain_mask = mask; base_addr = addr;
    for (int cyc = 0; cyc < 300; cyc++) begin
      start = (cyc == 0) || (cyc == restart_cyc);
      abort = (cyc == 0 && abort_at_start) ||
              (abort_beat >= 0 && wr_cnt == abort_beat && abort_apply_cyc < 0);
      if (abort && cyc > 0) abort_apply_cyc = cyc;
      dma.cmd_ready = 1'b1;
      dma.wr_ready  = !(stall_beat >= 0 && wr_cnt == stall_beat && stall_left > 0);
      dma.rd_valid  = rd_toggle ? ((cyc % 2) == 1) : 1'b1;
      dma.rd_data   = 64'hA0 + 64'(rd_cnt);
      #1;
      if (rst_in_prep && sc_se != '0 && !dma.wr_valid && busy) begin
        host_rst = 1'b1;
        #1;
        check_outputs_zero("rst_prep");
        @(negedge host_clk);
        host_rst = 1'b0;
        finished = 1;
        break;
      end
      if (dma.cmd_valid) begin
        if (cmdv_cnt == 0) begin
          cmd_addr_s = dma.cmd_addr; cmd_count_s = dma.cmd_count; cmd_dir_s = dma.cmd_dir;
        end else if ({cmd_addr_s, cmd_count_s, cmd_dir_s} !== {dma.cmd_addr, dma.cmd_count, dma.cmd_dir})
          cmd_unstable++;
        cmdv_cnt++;
      end
      if (sc_sr != '0) sr_log.push_back(sc_sr);
      if (sc_se[0]) se0_cnt++;
      if (sc_se[1]) begin
        se1_cnt++;
        if (dir) di_log.push_back(sc_di);
      end
      if (sc_se != '0 && !dma.wr_valid && !dma.rd_ready) prep_cyc++;
      if (dma.wr_valid && dma.wr_ready) begin
        wr_log.push_back(dma.wr_data);
        wr_cnt++;
      end
      if (dma.wr_valid && !dma.wr_ready) begin
        if (stall_left == 10) stall_data = dma.wr_data;
        else if (dma.wr_data !== stall_data) stall_bad++;
        if (sc_se != '0) stall_bad++;
        stall_left--;
      end
      if (dma.rd_valid && dma.rd_ready) rd_cnt++;
      rd_beats = rd_cnt;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (aborted) begin abort_cnt++; abort_cyc = cyc; busy_at_abort = int'(busy); end
      if ((done || aborted) && end_at < 0) end_at = cyc + 3;
      if (cyc == end_at) begin finished = 1; break; end
      @(negedge host_clk);
    end
    if (!finished) check("timeout", 64'h0, 64'h1);
    start = 1'b0; abort = 1'b0;
    @(negedge host_clk);
  endtask

  initial begin
    host_rst = 1'b1; start = 1'b0; direction = 1'b0; abort = 1'b0;
    base_addr = '0; chain_mask = '0;
    dma.cmd_ready = 1'b0; dma.rd_valid = 1'b0; dma.rd_data = '0; dma.wr_ready = 1'b0;
    stall_beat = -1; abort_beat = -1; restart_cyc = -1;
    rd_toggle = 0; abort_at_start = 0; rst_in_prep = 0;
    repeat (2) @(negedge host_clk);
    #1 check_outputs_zero("reset");
    @(negedge host_clk);
    host_rst = 1'b0;
    @(negedge host_clk);
    #1 check_outputs_zero("idle");
    @(negedge host_clk);

    // 1: full scan-out, with a start pulse mid-transfer that must be ignored.
    restart_cyc = 5;
    run_xfer(1'b0, 2'b11, 32'h1000);
    restart_cyc = -1;
    check("so_cmd_count", 64'(cmd_count_s), 64'd7);
    check("so_cmd_addr", 64'(cmd_addr_s), 64'h1000);
    check("so_cmd_dir", 64'(cmd_dir_s), 64'd0);
    check("so_cmd_stable", 64'(cmd_unstable), 64'd0);
    check("so_sr_n", 64'(sr_log.size()), 64'd2);
    if (sr_log.size() == 2) begin
      check("so_sr0", 64'(sr_log[0]), 64'b01);
      check("so_sr1", 64'(sr_log[1]), 64'b10);
    end
    check("so_prep", 64'(prep_cyc), 64'd2);
    check_wr("so", 7);
    check("so_done", 64'(done_cnt), 64'd1);
    check("so_aborted", 64'(abort_cnt), 64'd0);

    // 2: scan-in of chain 1 only, rd_valid every other cycle.
    rd_toggle = 1;
    run_xfer(1'b1, 2'b10, 32'h2000);
    rd_toggle = 0;
    check("si_cmd_count", 64'(cmd_count_s), 64'd4);
    check("si_cmd_dir", 64'(cmd_dir_s), 64'd1);
    check("si_se1", 64'(se1_cnt), 64'd4);
    check("si_se0", 64'(se0_cnt), 64'd0);
    check("si_rd_beats", 64'(rd_beats), 64'd4);
    for (int k = 0; k < 4 && k < di_log.size(); k++)
      check($sformatf("si_di%0d", k), di_log[k], 64'hA0 + 64'(k));
    check("si_done", 64'(done_cnt), 64'd1);

    // 3: empty mask goes straight to done without a command.
    run_xfer(1'b0, 2'b00, 32'h3000);
    check("m0_done", 64'(done_cnt), 64'd1);
    check("m0_done_lat", 64'(done_cyc >= 1 && done_cyc <= 2), 64'd1);
    check("m0_cmdv", 64'(cmdv_cnt), 64'd0);

    // 4: ten-cycle wr_ready stall inside chain 0.
    stall_beat = 1;
    run_xfer(1'b0, 2'b11, 32'h1000);
    stall_beat = -1;
    check("st_len", 64'(10 - stall_left), 64'd10);
    check("st_bad", 64'(stall_bad), 64'd0);
    check_wr("st", 7);
    check("st_done", 64'(done_cnt), 64'd1);

    // 5: abort on the second beat of chain 1, then a clean full run.
    abort_beat = 4;
    run_xfer(1'b0, 2'b11, 32'h1000);
    abort_beat = -1;
    check("ab_aborted", 64'(abort_cnt), 64'd1);
    check("ab_lat", 64'(abort_cyc - abort_apply_cyc), 64'd1);
    check("ab_busy", 64'(busy_at_abort), 64'd0);
    check("ab_done", 64'(done_cnt), 64'd0);
    check_wr("ab", 5);
    run_xfer(1'b0, 2'b11, 32'h1000);
    check_wr("ab_rerun", 7);
    check("ab_rerun_done", 64'(done_cnt), 64'd1);

    // 6: abort together with start in IDLE; start wins.
    abort_at_start = 1;
    run_xfer(1'b0, 2'b01, 32'h4000);
    abort_at_start = 0;
    check("as_aborted", 64'(abort_cnt), 64'd0);
    check_wr("as", 3);
    check("as_done", 64'(done_cnt), 64'd1);

    // 7: reset during chain 1 prep, then a normal transfer.
    rst_in_prep = 1;
    run_xfer(1'b0, 2'b10, 32'h5000);
    rst_in_prep = 0;
    check("rp_prep_seen", 64'(n_tests > 0 && prep_cyc == 0 && wr_log.size() == 0), 64'd1);
    run_xfer(1'b0, 2'b11, 32'h1000);
    check_wr("rp_rerun", 7);
    check("rp_rerun_cmd", 64'(cmd_count_s), 64'd7);
    check("rp_rerun_done", 64'(done_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
